zeroriscy_rf_reader: RTL and testbench



---
 rtl/zeroriscy_rf_reader_pkg.sv | 16 +
 rtl/zeroriscy_rf_reader_outbuf.sv | 53 +++++
 rtl/zeroriscy_rf_reader.sv | 164 ++++++++++++++++
 tb/tb_zeroriscy_rf_reader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroriscy_rf_reader_pkg.sv
// Shared types and constants for the zeroriscy register-file reader.
// Checksum beat support is selected by ZERORISCY_RF_READER_CHECKSUM_EN in the top.
package zeroriscy_rf_reader_pkg;

    localparam int unsigned RfAddrWidth  = 5;
    localparam int unsigned RfAddrWidthE = 4;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StDrain,
        StCsum,
        StDone
    } rf_rd_state_e;

endpackage

// File: rtl/zeroriscy_rf_reader_outbuf.sv
// Single-entry output register with valid/ready handshake; contents hold while stalled.
module zeroriscy_rf_reader_outbuf
    import zeroriscy_rf_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   load_i,
    input  logic [DATA_WIDTH-1:0]  load_data_i,
    input  logic [RfAddrWidth-1:0] load_addr_i,
    input  logic                   load_last_i,
    output logic                   free_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_WIDTH-1:0]  out_data_o,
    output logic [RfAddrWidth-1:0] out_addr_o,
    output logic                   out_last_o
);

    logic                   valid_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [RfAddrWidth-1:0] addr_q;
    logic                   last_q;

    // Room for a new word: empty now, or the held beat leaves this cycle.
    assign free_o = !valid_q || out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= load_data_i;
            addr_q  <= load_addr_i;
            last_q  <= load_last_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_addr_o  = addr_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/zeroriscy_rf_reader.sv
// Streams a range of register-file entries out as valid/ready beats.
// Define ZERORISCY_RF_READER_CHECKSUM_EN to append an XOR checksum beat.
module zeroriscy_rf_reader
    import zeroriscy_rf_reader_pkg::*;
#(
    parameter bit          RV32E      = 1'b0,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [RfAddrWidth-1:0] first_i,
    input  logic [RfAddrWidth-1:0] last_i,
    input  logic                   abort_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   rf_req_o,
    input  logic                   rf_gnt_i,
    output logic [RfAddrWidth-1:0] rf_raddr_o,
    input  logic [DATA_WIDTH-1:0]  rf_rdata_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_WIDTH-1:0]  out_data_o,
    output logic [RfAddrWidth-1:0] out_addr_o,
    output logic                   out_last_o
);

    localparam int unsigned AddrWidth = RV32E ? RfAddrWidthE : RfAddrWidth;
    localparam logic [RfAddrWidth-1:0] AddrMask = RfAddrWidth'((1 << AddrWidth) - 1);

    rf_rd_state_e           state_q, state_d;
    logic [RfAddrWidth-1:0] ptr_q, ptr_d;
    logic [RfAddrWidth-1:0] last_q, last_d;
    logic [RfAddrWidth-1:0] first_m, last_m;

    logic                   buf_free;
    logic                   buf_load;
    logic                   buf_clear;
    logic [DATA_WIDTH-1:0]  buf_data;
    logic [RfAddrWidth-1:0] buf_addr;
    logic                   buf_last;

`ifdef ZERORISCY_RF_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]  csum_q, csum_d;
`endif

    assign first_m    = first_i & AddrMask;
    assign last_m     = last_i & AddrMask;
    assign busy_o     = (state_q != StIdle);
    assign rf_req_o   = (state_q == StRead) && buf_free;
    assign rf_raddr_o = ptr_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        last_d    = last_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        buf_data  = rf_rdata_i;
        buf_addr  = ptr_q;
        buf_last  = 1'b0;
        done_o    = 1'b0;
`ifdef ZERORISCY_RF_READER_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        // Abort wins over any grant or transfer in the same cycle.
        if (abort_i && (state_q != StIdle)) begin
            state_d   = StIdle;
            buf_clear = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        ptr_d   = first_m;
                        last_d  = last_m;
                        state_d = (first_m > last_m) ? StDone : StRead;
`ifdef ZERORISCY_RF_READER_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
                StRead: begin
                    if (rf_req_o && rf_gnt_i) begin
                        buf_load = 1'b1;
`ifdef ZERORISCY_RF_READER_CHECKSUM_EN
                        csum_d   = csum_q ^ rf_rdata_i;
`else
                        buf_last = (ptr_q == last_q);
`endif
                        if (ptr_q == last_q) begin
                            state_d = StDrain;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (buf_free) begin
`ifdef ZERORISCY_RF_READER_CHECKSUM_EN
                        // Checksum beat replaces the final register beat as it leaves.
                        buf_load = 1'b1;
                        buf_data = csum_q;
                        buf_addr = '0;
                        buf_last = 1'b1;
                        state_d  = StCsum;
`else
                        state_d  = StDone;
`endif
                    end
                end
`ifdef ZERORISCY_RF_READER_CHECKSUM_EN
                StCsum: begin
                    if (buf_free) begin
                        state_d = StDone;
                    end
                end
`endif
                StDone: begin
                    done_o  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            last_q  <= '0;
`ifdef ZERORISCY_RF_READER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
`ifdef ZERORISCY_RF_READER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    zeroriscy_rf_reader_outbuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_outbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (buf_clear),
        .load_i      (buf_load),
        .load_data_i (buf_data),
        .load_addr_i (buf_addr),
        .load_last_i (buf_last),
        .free_o      (buf_free),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_addr_o  (out_addr_o),
        .out_last_o  (out_last_o)
    );

endmodule

// File: tb/tb_zeroriscy_rf_reader.sv
// Random and directed dumps on an RV32I and an RV32E instance, checked against a beat-list model.
// Checksum beats are expected when ZERORISCY_RF_READER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_zeroriscy_rf_reader;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        last;
    } beat_t;

`ifdef ZERORISCY_RF_READER_CHECKSUM_EN
    localparam bit CsumEn = 1'b1;
`else
    localparam bit CsumEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        rf_gnt_i = 1'b0;
    logic        out_ready_i = 1'b0;
    logic [4:0]  first_i = '0;
    logic [4:0]  last_i = '0;

    logic        busy [2];
    logic        done [2];
    logic        rf_req [2];
    logic        out_valid [2];
    logic        out_last [2];
    logic [4:0]  raddr [2];
    logic [4:0]  out_addr [2];
    logic [31:0] rdata [2];
    logic [31:0] out_data [2];
    logic [31:0] mem [32];

    int    n_checks = 0;
    int    n_errors = 0;
    int    gnt_mode = 0;
    int    rdy_mode = 0;
    int    stall = 0;
    int    beats [2];
    int    dones [2];
    bit    held_v [2];
    beat_t held [2];
    beat_t expq0 [$];
    beat_t expq1 [$];

    assign rdata[0] = mem[raddr[0]];
    assign rdata[1] = mem[raddr[1]];

    always #5 clk = ~clk;

    zeroriscy_rf_reader #(.RV32E(1'b0), .DATA_WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .first_i(first_i), .last_i(last_i),
        .abort_i(abort_i), .busy_o(busy[0]), .done_o(done[0]), .rf_req_o(rf_req[0]),
        .rf_gnt_i(rf_gnt_i), .rf_raddr_o(raddr[0]), .rf_rdata_i(rdata[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready_i), .out_data_o(out_data[0]),
        .out_addr_o(out_addr[0]), .out_last_o(out_last[0])
    );

    zeroriscy_rf_reader #(.RV32E(1'b1), .DATA_WIDTH(32)) u_dut_e (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .first_i(first_i), .last_i(last_i),
        .abort_i(abort_i), .busy_o(busy[1]), .done_o(done[1]), .rf_req_o(rf_req[1]),
        .rf_gnt_i(rf_gnt_i), .rf_raddr_o(raddr[1]), .rf_rdata_i(rdata[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready_i), .out_data_o(out_data[1]),
        .out_addr_o(out_addr[1]), .out_last_o(out_last[1])
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: the dump is simply every masked index first..last, then the XOR beat if enabled.
    task automatic build_exp(input int inst, input logic [4:0] f, input logic [4:0] l);
        int          top;
        int          fm;
        int          lm;
        logic [31:0] x;
        beat_t       b;
        top = (inst == 1) ? 15 : 31;
        fm  = int'(f) % (top + 1);
        lm  = int'(l) % (top + 1);
        x   = '0;
        for (int k = fm; k <= lm; k++) begin
            b.data = mem[k];
            b.addr = 5'(k);
            b.last = !CsumEn && (k == lm);
            x      = x ^ mem[k];
            if (inst == 0) expq0.push_back(b);
            else           expq1.push_back(b);
        end
        if (CsumEn && fm <= lm) begin
            b.data = x;
            b.addr = '0;
            b.last = 1'b1;
            if (inst == 0) expq0.push_back(b);
            else           expq1.push_back(b);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        case (gnt_mode)
            0:       rf_gnt_i = 1'b1;
            1:       rf_gnt_i = !rf_gnt_i;
            default: rf_gnt_i = ($urandom_range(3) != 0);
        endcase
        case (rdy_mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = ($urandom_range(2) != 0);
            default: out_ready_i = 1'b0;
        endcase
        if (stall > 0) begin
            out_ready_i = 1'b0;
            stall--;
        end
    endtask

    task automatic fill_mem();
        for (int k = 0; k < 32; k++) mem[k] = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_val({tag, "_valid"}, out_valid[i], 0);
            check_val({tag, "_last"}, out_last[i], 0);
            check_val({tag, "_done"}, done[i], 0);
            check_val({tag, "_busy"}, busy[i], 0);
            check_val({tag, "_req"}, rf_req[i], 0);
            check_val({tag, "_data"}, out_data[i], 0);
            check_val({tag, "_addr"}, out_addr[i], 0);
        end
    endtask

    task automatic run_dump(input logic [4:0] f, input logic [4:0] l,
                            input int stall_at, input int poke_at);
        int n;
        expq0.delete();
        expq1.delete();
        build_exp(0, f, l);
        build_exp(1, f, l);
        dones[0] = 0;
        dones[1] = 0;
        first_i  = f;
        last_i   = l;
        start_i  = 1'b1;
        step();
        start_i  = 1'b0;
        n = 0;
        while ((busy[0] || busy[1]) && n < 3000) begin
            if (n == stall_at) stall = 5;
            // A start while both are busy must be ignored.
            if (n == poke_at && busy[0] && busy[1]) begin
                first_i = 5'd0;
                last_i  = 5'd1;
                start_i = 1'b1;
            end
            step();
            start_i = 1'b0;
            n++;
        end
        check_val("dump_timeout", n < 3000, 1);
        check_val("beats_left0", expq0.size(), 0);
        check_val("beats_left1", expq1.size(), 0);
        check_val("done_count0", dones[0], 1);
        check_val("done_count1", dones[1], 1);
    endtask

    // Beat monitor: ordering, contents, hold stability and request back-pressure.
    initial begin
        beat_t got;
        beat_t exp;
        int    qs;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    held_v[i] = 1'b0;
                end else begin
                    got = {out_data[i], out_addr[i], out_last[i]};
                    if (held_v[i] && out_valid[i]) check_val("hold_stable", got, held[i]);
                    if (out_valid[i] && !out_ready_i && busy[i])
                        check_val("req_while_stalled", rf_req[i], 0);
                    if (out_valid[i] && out_ready_i) begin
                        beats[i]++;
                        qs = (i == 0) ? expq0.size() : expq1.size();
                        check_val("beat_expected", qs > 0, 1);
                        if (qs > 0) begin
                            if (i == 0) exp = expq0.pop_front();
                            else        exp = expq1.pop_front();
                            check_val((i == 0) ? "beat" : "beat_e", got, exp);
                        end
                    end
                    held_v[i] = out_valid[i] && !out_ready_i;
                    held[i]   = got;
                    if (done[i]) dones[i]++;
                end
            end
        end
    end

    initial begin
        int n;
        fill_mem();
        beats[0] = 0;
        beats[1] = 0;
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Short ascending dump with everything always ready.
        run_dump(5'd1, 5'd3, -1, -1);
        // Index 0 included, alternating grants.
        gnt_mode = 1;
        run_dump(5'd0, 5'd7, -1, -1);
        gnt_mode = 0;
        // Five-cycle sink stall mid-dump, plus an ignored start while busy.
        run_dump(5'd2, 5'd12, 3, 5);
        // RV32E instance masks last to 15.
        run_dump(5'd14, 5'd31, -1, -1);
        // Checksum pattern.
        mem[1] = 32'hA5A5_0000;
        mem[2] = 32'h0000_5A5A;
        run_dump(5'd1, 5'd2, -1, -1);

        // Empty range: done on the cycle right after start.
        expq0.delete();
        expq1.delete();
        first_i = 5'd5;
        last_i  = 5'd2;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check_val("empty_done", done[0], 1);
        check_val("empty_done_e", done[1], 1);
        step();
        check_val("empty_done_once", done[0], 0);
        check_val("empty_idle", busy[0], 0);

        // Abort after two accepted beats.
        fill_mem();
        expq0.delete();
        expq1.delete();
        build_exp(0, 5'd3, 5'd9);
        build_exp(1, 5'd3, 5'd9);
        beats[0] = 0;
        dones[0] = 0;
        dones[1] = 0;
        first_i  = 5'd3;
        last_i   = 5'd9;
        start_i  = 1'b1;
        step();
        start_i  = 1'b0;
        n = 0;
        while (beats[0] < 2 && n < 100) begin
            step();
            n++;
        end
        check_val("abort_setup_timeout", n < 100, 1);
        rdy_mode    = 2;
        out_ready_i = 1'b0;
        abort_i     = 1'b1;
        step();
        abort_i     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_val("abort_busy", busy[i], 0);
            check_val("abort_valid", out_valid[i], 0);
            check_val("abort_req", rf_req[i], 0);
        end
        repeat (4) step();
        check_val("abort_no_done0", dones[0], 0);
        check_val("abort_no_done1", dones[1], 0);
        rdy_mode = 0;
        run_dump(5'd4, 5'd6, -1, -1);

        // Reset asserted mid-dump.
        fill_mem();
        expq0.delete();
        expq1.delete();
        build_exp(0, 5'd0, 5'd20);
        build_exp(1, 5'd0, 5'd20);
        first_i = 5'd0;
        last_i  = 5'd20;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        step();
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        expq0.delete();
        expq1.delete();
        step();
        run_dump(5'd9, 5'd11, -1, -1);

        // Random ranges under random grant and back-pressure.
        gnt_mode = 2;
        rdy_mode = 1;
        for (int r = 0; r < 25; r++) begin
            fill_mem();
            run_dump(5'($urandom_range(31)), 5'($urandom_range(31)), -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
